// File: rtl/simon_key_sched_if.sv
// Key-schedule port bundle: key load handshake, status flags and round-key read port.
// The master drives key/k_valid/rk_addr; the slave (the key schedule) answers.
interface simon_key_sched_if #(
  parameter int WORD_WIDTH = 32,
  parameter int KEY_WORDS  = 4,
  parameter int ROUNDS     = 44
);
  localparam int AW = $clog2(ROUNDS);

  logic [WORD_WIDTH*KEY_WORDS-1:0] key;
  logic                            k_valid;
  logic                            k_ready;
  logic                            exp_valid;
  logic                            busy;
  logic [AW-1:0]                   rk_addr;
  logic [WORD_WIDTH-1:0]           rk_data;
  logic                            rk_hit;

  modport master (
    output key, k_valid, rk_addr,
    input  k_ready, exp_valid, busy, rk_data, rk_hit
  );

  modport slave (
    input  key, k_valid, rk_addr,
    output k_ready, exp_valid, busy, rk_data, rk_hit
  );
endinterface

// File: rtl/simon_key_sched.sv
// Simon key expansion: loads an m-word master key, generates one round key per cycle,
// and serves any generated word through a registered read port while expansion runs.
module simon_key_sched #(
  parameter int WORD_WIDTH = 32,
  parameter int KEY_WORDS  = 4,
  parameter int ROUNDS     = 44,
  parameter int Z_INDEX    = 3
) (
  input logic              ck,
  input logic              nrst,
  simon_key_sched_if.slave bus
);

  localparam int AW = $clog2(ROUNDS);
  localparam int CW = $clog2(ROUNDS + 1);

  // Published z sequences: leftmost character sits at bit 61 of each literal.
  function automatic logic [61:0] z_published(input int idx);
    case (idx)
      0:       z_published = 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       z_published = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       z_published = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       z_published = 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: z_published = 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  function automatic logic [61:0] bit_reverse62(input logic [61:0] v);
    bit_reverse62 = '0;
    for (int j = 0; j < 62; j++) begin
      bit_reverse62[j] = v[61-j];
    end
  endfunction

  localparam logic [61:0] Z_SEQ = bit_reverse62(z_published(Z_INDEX));

  function automatic logic [WORD_WIDTH-1:0] ror1(input logic [WORD_WIDTH-1:0] x);
    ror1 = {x[0], x[WORD_WIDTH-1:1]};
  endfunction

  function automatic logic [WORD_WIDTH-1:0] ror3(input logic [WORD_WIDTH-1:0] x);
    ror3 = {x[2:0], x[WORD_WIDTH-1:3]};
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [5:0]            z_idx;
  logic                  k_ready_q;
  logic                  busy_q;
  logic                  exp_valid_q;
  logic [WORD_WIDTH-1:0] rk_data_q;
  logic                  rk_hit_q;

  logic [WORD_WIDTH-1:0] k_mem [ROUNDS];

  logic                  accept;
  logic                  last_write;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         prev1_idx;
  logic [AW-1:0]         prev3_idx;
  logic [AW-1:0]         prevm_idx;
  logic [CW-1:0]         addr_x;
  logic [WORD_WIDTH-1:0] tmp;
  logic [WORD_WIDTH-1:0] next_word;

  assign accept     = bus.k_valid && k_ready_q;
  assign last_write = (state == EXP) && (count == CW'(ROUNDS - 1));
  assign wr_idx     = AW'(count);
  assign prev1_idx  = wr_idx - AW'(1);
  assign prev3_idx  = wr_idx - AW'(3);
  assign prevm_idx  = wr_idx - AW'(KEY_WORDS);
  assign addr_x     = CW'(bus.rk_addr);

  // z is walked with its own wrapping pointer so (count-m) mod 62 needs no divider.
  always_comb begin
    tmp = ror3(k_mem[prev1_idx]);
    if (KEY_WORDS == 4) begin
      tmp = tmp ^ k_mem[prev3_idx];
    end
    tmp       = tmp ^ ror1(tmp);
    next_word = ~k_mem[prevm_idx] ^ tmp ^ WORD_WIDTH'(Z_SEQ[z_idx]) ^ WORD_WIDTH'(3);
  end

  // Key storage carries no reset; rk_hit alone tells the reader which words are valid.
  always_ff @(posedge ck) begin
    if (accept) begin
      for (int j = 0; j < KEY_WORDS; j++) begin
        k_mem[AW'(j)] <= bus.key[j*WORD_WIDTH +: WORD_WIDTH];
      end
    end else if (state == EXP) begin
      k_mem[wr_idx] <= next_word;
    end
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      count       <= '0;
      z_idx       <= '0;
      k_ready_q   <= 1'b1;
      busy_q      <= 1'b0;
      exp_valid_q <= 1'b0;
      rk_data_q   <= '0;
      rk_hit_q    <= 1'b0;
    end else begin
      // The read sees count before this edge, so a word being written now reports no hit.
      if (addr_x >= CW'(ROUNDS)) begin
        rk_data_q <= '0;
        rk_hit_q  <= 1'b0;
      end else begin
        rk_data_q <= k_mem[bus.rk_addr];
        rk_hit_q  <= (addr_x < count) && (state != IDLE);
      end

      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state       <= EXP;
            count       <= CW'(KEY_WORDS);
            z_idx       <= '0;
            k_ready_q   <= 1'b0;
            busy_q      <= 1'b1;
            exp_valid_q <= 1'b0;
          end
        end
        EXP: begin
          count <= count + CW'(1);
          z_idx <= (z_idx == 6'd61) ? 6'd0 : z_idx + 6'd1;
          if (last_write) begin
            state       <= DONE;
            k_ready_q   <= 1'b1;
            busy_q      <= 1'b0;
            exp_valid_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          k_ready_q   <= 1'b1;
          busy_q      <= 1'b0;
          exp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.k_ready   = k_ready_q;
  assign bus.busy      = busy_q;
  assign bus.exp_valid = exp_valid_q;
  assign bus.rk_data   = rk_data_q;
  assign bus.rk_hit    = rk_hit_q;

endmodule

// File: tb/tb_simon_key_sched.sv
// Bench for simon_key_sched: Simon64/128, Simon32/64 and Simon128/128 instances checked
// against a word-level schedule model, golden constants and timing rules.
module tb_simon_key_sched;

  logic ck;
  logic nrst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [63:0] model_k [72];

  typedef struct {
    int          addr;
    logic [63:0] data;
    logic        hit;
  } vec_t;

  vec_t vecs [$];

  simon_key_sched_if #(.WORD_WIDTH(32), .KEY_WORDS(4), .ROUNDS(44)) if_a ();
  simon_key_sched_if #(.WORD_WIDTH(16), .KEY_WORDS(4), .ROUNDS(32)) if_b ();
  simon_key_sched_if #(.WORD_WIDTH(64), .KEY_WORDS(2), .ROUNDS(68)) if_c ();

  simon_key_sched #(.WORD_WIDTH(32), .KEY_WORDS(4), .ROUNDS(44), .Z_INDEX(3)) u_a (
    .ck(ck), .nrst(nrst), .bus(if_a)
  );
  simon_key_sched #(.WORD_WIDTH(16), .KEY_WORDS(4), .ROUNDS(32), .Z_INDEX(0)) u_b (
    .ck(ck), .nrst(nrst), .bus(if_b)
  );
  simon_key_sched #(.WORD_WIDTH(64), .KEY_WORDS(2), .ROUNDS(68), .Z_INDEX(2)) u_c (
    .ck(ck), .nrst(nrst), .bus(if_c)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic string z_str(int zi);
    case (zi)
      0:       return "11111010001001010110000111001101111101000100101011000011100110";
      1:       return "10001110111110010011000010110101000111011111001001100001011010";
      2:       return "10101111011100000011010010011000101000010001111110010110110011";
      3:       return "11011011101011000110010111100000010010001010011100110100001111";
      default: return "11010001111001101011011000100000010111000011001010010011101111";
    endcase
  endfunction

  function automatic logic [63:0] word_mask(int n);
    return (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] rotr(logic [63:0] x, int r, int n);
    logic [63:0] m;
    logic [63:0] v;
    m = word_mask(n);
    v = x & m;
    return ((v >> r) | (v << (n - r))) & m;
  endfunction

  // Whole schedule from the master key, straight from the round-key recurrence.
  task automatic build_model(int n, int m, int t, int zi, logic [127:0] key);
    logic [63:0] mask;
    logic [63:0] tmp;
    logic [63:0] zc;
    string       zs;
    mask = word_mask(n);
    zs   = z_str(zi);
    for (int j = 0; j < m; j++) begin
      model_k[j] = 64'(key >> (j * n)) & mask;
    end
    for (int i = m; i < t; i++) begin
      tmp = rotr(model_k[i-1], 3, n);
      if (m == 4) tmp = tmp ^ model_k[i-3];
      tmp = tmp ^ rotr(tmp, 1, n);
      zc  = (zs[(i - m) % 62] == 8'h31) ? 64'd1 : 64'd0;
      model_k[i] = (~model_k[i-m] ^ tmp ^ zc ^ 64'd3) & mask;
    end
  endtask

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic set_inputs(int which, logic [127:0] key, logic valid);
    case (which)
      0:       begin if_a.key = 128'(key); if_a.k_valid = valid; end
      1:       begin if_b.key = 64'(key);  if_b.k_valid = valid; end
      default: begin if_c.key = 128'(key); if_c.k_valid = valid; end
    endcase
  endtask

  task automatic set_addr(int which, int addr);
    case (which)
      0:       if_a.rk_addr = 6'(addr);
      1:       if_b.rk_addr = 5'(addr);
      default: if_c.rk_addr = 7'(addr);
    endcase
  endtask

  task automatic peek(int which, output logic [63:0] data, output logic hit);
    case (which)
      0:       begin data = 64'(if_a.rk_data); hit = if_a.rk_hit; end
      1:       begin data = 64'(if_b.rk_data); hit = if_b.rk_hit; end
      default: begin data = 64'(if_c.rk_data); hit = if_c.rk_hit; end
    endcase
  endtask

  task automatic get_status(int which, output logic ready, output logic valid, output logic bsy);
    case (which)
      0:       begin ready = if_a.k_ready; valid = if_a.exp_valid; bsy = if_a.busy; end
      1:       begin ready = if_b.k_ready; valid = if_b.exp_valid; bsy = if_b.busy; end
      default: begin ready = if_c.k_ready; valid = if_c.exp_valid; bsy = if_c.busy; end
    endcase
  endtask

  task automatic check_reset_state(int which, string tag);
    logic [63:0] d;
    logic        h, r, v, b;
    peek(which, d, h);
    get_status(which, r, v, b);
    check_output({tag, " k_ready"}, 64'(r), 64'd1);
    check_output({tag, " exp_valid"}, 64'(v), 64'd0);
    check_output({tag, " busy"}, 64'(b), 64'd0);
    check_output({tag, " rk_data"}, d, 64'd0);
    check_output({tag, " rk_hit"}, 64'(h), 64'd0);
  endtask

  task automatic apply_stimulus(int which, int addr, output logic [63:0] data, output logic hit);
    set_addr(which, addr);
    tick();
    peek(which, data, hit);
  endtask

  task automatic accept_key(int which, logic [127:0] key, logic hold, string tag);
    logic r, v, b;
    set_inputs(which, key, 1'b1);
    tick();
    if (!hold) set_inputs(which, key, 1'b0);
    get_status(which, r, v, b);
    check_output({tag, " k_ready after accept"}, 64'(r), 64'd0);
    check_output({tag, " busy after accept"}, 64'(b), 64'd1);
    check_output({tag, " exp_valid after accept"}, 64'(v), 64'd0);
  endtask

  task automatic wait_done(int which, int nominal, string tag);
    int   edges;
    logic r, v, b;
    edges = 0;
    v     = 1'b0;
    while (!v && edges < nominal + 20) begin
      tick();
      edges++;
      get_status(which, r, v, b);
    end
    check_output({tag, " exp_valid latency"}, 64'(edges), 64'(nominal));
    check_output({tag, " k_ready in DONE"}, 64'(r), 64'd1);
    check_output({tag, " busy in DONE"}, 64'(b), 64'd0);
  endtask

  task automatic load_readback(int t, int span);
    vecs.delete();
    for (int a = 0; a < span; a++) begin
      vecs.push_back('{addr: a, data: (a < t) ? model_k[a] : 64'd0, hit: (a < t)});
    end
  endtask

  task automatic run_table(int which, string tag);
    logic [63:0] d;
    logic        h;
    foreach (vecs[i]) begin
      apply_stimulus(which, vecs[i].addr, d, h);
      check_output($sformatf("%s rk_hit[%0d]", tag, vecs[i].addr), 64'(h), 64'(vecs[i].hit));
      check_output($sformatf("%s rk_data[%0d]", tag, vecs[i].addr), d, vecs[i].data);
    end
  endtask

  initial begin
    logic [127:0] key;
    logic [63:0]  d;
    logic         h, r, v, b;
    int           addr;

    nrst = 1'b1;
    for (int w = 0; w < 3; w++) begin
      set_inputs(w, 128'd0, 1'b0);
      set_addr(w, 0);
    end

    #1 nrst = 1'b0;
    #1;
    check_reset_state(0, "A reset");
    check_reset_state(1, "B reset");
    check_reset_state(2, "C reset");
    repeat (2) @(posedge ck);
    #1 nrst = 1'b1;

    // Simon64/128 reference key, polling the word being written and the one just written
    key = 128'h1b1a1918_13121110_0b0a0908_03020100;
    build_model(32, 4, 44, 3, key);
    accept_key(0, key, 1'b0, "A ref");
    for (int c = 0; c < 40; c++) begin
      addr = (c % 2 == 0) ? 4 + c : 3 + c;
      apply_stimulus(0, addr, d, h);
      get_status(0, r, v, b);
      check_output($sformatf("A poll rk_hit[%0d]", addr), 64'(h), (c % 2 == 0) ? 64'd0 : 64'd1);
      if (c % 2 == 1) check_output($sformatf("A poll rk_data[%0d]", addr), d, model_k[addr]);
      check_output($sformatf("A exp_valid edge %0d", c + 1), 64'(v), (c + 1 == 40) ? 64'd1 : 64'd0);
    end
    load_readback(44, 64);
    run_table(0, "A ref");

    // Re-key from DONE while k_valid stays high through the whole expansion
    key = {$urandom, $urandom, $urandom, $urandom};
    build_model(32, 4, 44, 3, key);
    accept_key(0, key, 1'b1, "A hold");
    set_inputs(0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    wait_done(0, 40, "A hold");
    set_inputs(0, key, 1'b0);
    load_readback(44, 44);
    run_table(0, "A hold");

    for (int it = 0; it < 3; it++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      build_model(32, 4, 44, 3, key);
      accept_key(0, key, 1'b0, "A rand");
      wait_done(0, 40, "A rand");
      for (int k = 0; k < 8; k++) begin
        addr = int'($urandom_range(0, 63));
        apply_stimulus(0, addr, d, h);
        check_output($sformatf("A rand rk_hit[%0d]", addr), 64'(h), (addr < 44) ? 64'd1 : 64'd0);
        check_output($sformatf("A rand rk_data[%0d]", addr), d, (addr < 44) ? model_k[addr] : 64'd0);
      end
    end

    // Reset dropped in the middle of an expansion
    key = {$urandom, $urandom, $urandom, $urandom};
    accept_key(0, key, 1'b0, "A abort");
    repeat (10) tick();
    #1 nrst = 1'b0;
    #1;
    check_reset_state(0, "A mid-EXP reset");
    @(posedge ck);
    #1 nrst = 1'b1;
    get_status(0, r, v, b);
    check_output("A after release k_ready", 64'(r), 64'd1);
    for (int a = 0; a < 64; a++) begin
      apply_stimulus(0, a, d, h);
      check_output($sformatf("A after release rk_hit[%0d]", a), 64'(h), 64'd0);
    end
    get_status(0, r, v, b);
    check_output("A after release exp_valid", 64'(v), 64'd0);
    check_output("A after release busy", 64'(b), 64'd0);

    // Simon32/64 reference key with published first round keys
    key = 128'h1918_1110_0908_0100;
    build_model(16, 4, 32, 0, key);
    accept_key(1, key, 1'b0, "B ref");
    wait_done(1, 28, "B ref");
    load_readback(32, 32);
    vecs.push_back('{addr: 0, data: 64'h0100, hit: 1'b1});
    vecs.push_back('{addr: 1, data: 64'h0908, hit: 1'b1});
    vecs.push_back('{addr: 2, data: 64'h1110, hit: 1'b1});
    vecs.push_back('{addr: 3, data: 64'h1918, hit: 1'b1});
    vecs.push_back('{addr: 4, data: 64'h71C3, hit: 1'b1});
    vecs.push_back('{addr: 5, data: 64'hB649, hit: 1'b1});
    run_table(1, "B ref");

    // Simon128/128, including every out-of-range address
    key = 128'h0f0e0d0c0b0a0908_0706050403020100;
    build_model(64, 2, 68, 2, key);
    accept_key(2, key, 1'b0, "C ref");
    wait_done(2, 66, "C ref");
    load_readback(68, 128);
    run_table(2, "C ref");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_key_sched.md
SIMON_KEY_SCHED -- requirements
Module: simon_key_sched

Parameters
REQ-001 SHALL provide WORD_WIDTH, default 32; round-key word size n; legal values 16, 24, 32, 48, 64.
REQ-002 SHALL provide KEY_WORDS, default 4; key word count m; legal values 2, 3, 4.
REQ-003 SHALL provide ROUNDS, default 44; total round keys T; legal range KEY_WORDS+1 to 72.
REQ-004 SHALL provide Z_INDEX, default 3; selects Simon constant sequence z0..z4.
- Each sequence is stored as 62 bits, published character j at bit j.
- Index into the sequence is (i-m) mod 62.
REQ-005 SHALL derive AW = clog2(ROUNDS) for the read address width.

Interface
REQ-006 ck  in  1  clock; all state updates on the rising edge.
REQ-007 nrst  in  1  reset; one clock, asynchronous assert, active-low.
REQ-008 key  in  WORD_WIDTH*KEY_WORDS  master key; word j = key[j*n +: n].
REQ-009 k_valid  in  1  key offered.
REQ-010 k_ready  out  1  block can accept a key.
REQ-011 exp_valid  out  1  full schedule available.
REQ-012 busy  out  1  expansion in progress.
REQ-013 rk_addr  in  AW  round-key read index.
REQ-014 rk_data  out  WORD_WIDTH  registered read data.
REQ-015 rk_hit  out  1  registered flag: rk_data holds a generated key.

Function
REQ-016 FSM states SHALL be IDLE, EXP, DONE.
- k_ready = IDLE or DONE.
- busy = EXP.
- exp_valid = DONE.
REQ-017 Accept SHALL occur on an edge with k_valid and k_ready both high. On accept:
- words k[0..m-1] are written from key;
- count is set to m;
- state goes to EXP.
REQ-018 In EXP, each edge SHALL write k[count] and increment count.
- tmp = ROR3(k[count-1]).
- If m=4, tmp ^= k[count-3].
- tmp ^= ROR1(tmp).
- k[count] = ~k[count-m] ^ tmp ^ z[(count-m) mod 62] ^ 3.
- All arithmetic is n bits wide.
REQ-019 The edge that writes k[T-1] SHALL move the state to DONE.
- EXP lasts exactly T-m cycles.
- exp_valid rises T-m cycles after the accept edge.
REQ-020 k_valid in EXP SHALL be ignored; there is no queueing and no abort.
REQ-021 k_valid in DONE SHALL be a re-key: same behaviour as accept from IDLE.
- exp_valid drops on that edge.
- count restarts at m; older words above m are stale until rewritten.
REQ-022 Read port SHALL have 1-cycle latency. On each edge:
- rk_data <= k[rk_addr];
- rk_hit <= (rk_addr < count) and not IDLE.
- When rk_addr >= T: rk_data <= 0 and rk_hit <= 0.
REQ-023 A read of the index being written on the same edge SHALL return rk_hit=0; the write is not forwarded.
REQ-024 The read port SHALL work in every state, including during EXP, for progressive consumption by the cipher datapath.
REQ-025 The z sequence SHALL be a compile-time constant. No runtime mode input; one instance serves one Simon configuration.

Reset
REQ-026 With nrst low, the following SHALL hold immediately, independent of ck:
- state = IDLE, count = 0;
- k_ready = 1, exp_valid = 0, busy = 0;
- rk_data = 0, rk_hit = 0.
REQ-027 Key storage SHALL NOT be reset; its contents are don't-care.
- rk_hit stays 0 for every address until the next accept.
REQ-028 Reset asserted mid-EXP SHALL abandon the expansion.
- After release, behaviour is that of IDLE.
- No stale exp_valid.
REQ-029 Deassertion of nrst SHALL be synchronous to ck at the instance boundary; the synchroniser is external.

Verification
REQ-030 Simon32/64, key 0x1918_1110_0908_0100 -> k[0..3] = 0100, 0908, 1110, 1918; k[4] = 0x71C3. exp_valid rises 28 cycles after accept. k[31] matches the golden model.
REQ-031 Simon64/128, key 0x1b1a1918_13121110_0b0a0908_03020100 -> all 44 words match the golden model; exp_valid at accept+40.
REQ-032 Simon128/128 (n=64, m=2, T=68, z2) -> all 68 words match the golden model. rk_addr=68..127 gives rk_hit=0, rk_data=0.
REQ-033 Poll rk_addr = count each cycle during EXP -> rk_hit=0. rk_addr = count-1 -> rk_hit=1 with correct data one cycle later.
REQ-034 Hold k_valid high throughout EXP -> no restart; exp_valid at nominal cycle. Then re-key in DONE with a new key -> exp_valid low for T-m cycles, new schedule correct.
REQ-035 Assert nrst at cycle 10 of EXP -> outputs at reset values with no clock edge. After release, k_ready=1, rk_hit=0 for all addresses.
